// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: buffers scancode bytes and sends 11-bit frames.
// Define PS2_TX_FIFO_EN for a FIFO_DEPTH-byte FIFO; otherwise a single holding register is used.
module ps2_kbd_tx #(
  parameter int unsigned PS2DIV     = 1103,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       i_clk_sys,
  input  logic       i_reset,
  input  logic [7:0] i_key_data,
  input  logic       i_key_strobe,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_ps2_clk_out,
  output logic       o_ps2_data_out
);

  localparam int unsigned DivW = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PS2DIV - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e          r_state, w_state_d;
  logic [DivW-1:0] r_div;
  logic            r_phase;
  logic [3:0]      r_bit;
  logic [9:0]      r_shift;
  logic            r_clk, r_data, r_full, r_overflow, r_busy;
  logic            w_tick, w_wr, w_pop, w_empty, w_full_d, w_clk_d, w_data_d;
  logic [7:0]      w_rd_data;

  assign w_wr   = i_key_strobe && !r_full;
  assign w_tick = (r_state != StIdle) && (r_div == DivLast);

`ifdef PS2_TX_FIFO_EN
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AddrW:0] r_wptr, r_rptr, w_wptr_d, w_rptr_d;

  assign w_wptr_d  = w_wr  ? r_wptr + PtrOne : r_wptr;
  assign w_rptr_d  = w_pop ? r_rptr + PtrOne : r_rptr;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full_d  = (w_wptr_d[AddrW] != w_rptr_d[AddrW]) &&
                     (w_wptr_d[AddrW-1:0] == w_rptr_d[AddrW-1:0]);
  assign w_rd_data = r_mem[r_rptr[AddrW-1:0]];

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_d;
      r_rptr <= w_rptr_d;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (w_wr) r_mem[r_wptr[AddrW-1:0]] <= i_key_data;
  end
`else
  logic       r_hold_vld;
  logic [7:0] r_hold;
  logic [8:0] w_unused_depth;

  assign w_unused_depth = 9'(FIFO_DEPTH);
  assign w_empty        = !r_hold_vld;
  assign w_full_d       = (r_hold_vld && !w_pop) || w_wr;
  assign w_rd_data      = r_hold;

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_hold_vld <= 1'b0;
      r_hold     <= 8'h00;
    end else begin
      r_hold_vld <= w_full_d;
      if (w_wr) r_hold <= i_key_data;
    end
  end
`endif

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_d = StSend;
      StSend:  if (w_tick && r_phase && (r_bit == 4'd10)) w_state_d = StGap;
      StGap:   if (w_tick && r_phase) w_state_d = w_empty ? StIdle : StSend;
      default: w_state_d = StIdle;
    endcase
  end

  // Line levels for the next cycle; a pop always presents the start bit immediately.
  always_comb begin
    w_clk_d  = r_clk;
    w_data_d = r_data;
    w_pop    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_clk_d  = 1'b1;
        w_data_d = 1'b1;
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_data_d = 1'b0;
        end
      end
      StSend: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_clk_d = 1'b0;
          end else begin
            w_clk_d  = 1'b1;
            w_data_d = (r_bit == 4'd10) ? 1'b1 : r_shift[0];
          end
        end
      end
      StGap: begin
        w_clk_d  = 1'b1;
        w_data_d = 1'b1;
        if (w_tick && r_phase && !w_empty) begin
          w_pop    = 1'b1;
          w_data_d = 1'b0;
        end
      end
      default: begin
        w_clk_d  = 1'b1;
        w_data_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_div      <= '0;
      r_phase    <= 1'b0;
      r_bit      <= 4'd0;
      r_shift    <= 10'h3ff;
      r_clk      <= 1'b1;
      r_data     <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (r_state == StIdle || w_tick) r_div <= '0;
      else                             r_div <= r_div + 1'b1;
      if (r_state == StIdle) r_phase <= 1'b0;
      else if (w_tick)       r_phase <= ~r_phase;
      if (w_pop) begin
        r_bit   <= 4'd0;
        r_shift <= {1'b1, ~^w_rd_data, w_rd_data};
      end else if (r_state == StSend && w_tick && r_phase && r_bit != 4'd10) begin
        r_bit   <= r_bit + 4'd1;
        r_shift <= {1'b1, r_shift[9:1]};
      end
      r_clk      <= w_clk_d;
      r_data     <= w_data_d;
      r_full     <= w_full_d;
      r_overflow <= i_key_strobe && r_full;
      r_busy     <= (r_state != StIdle) || !w_empty || w_wr;
    end
  end

  assign o_full         = r_full;
  assign o_overflow     = r_overflow;
  assign o_busy         = r_busy;
  assign o_ps2_clk_out  = r_clk;
  assign o_ps2_data_out = r_data;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: scoreboarded frame capture on PS/2 clock falls plus timing checks.
module tb_ps2_kbd_tx;
  localparam int unsigned Div   = 4;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] kdata = 8'h00;
  logic       full, ovf, busy, ps2_clk, ps2_data;

  ps2_kbd_tx #(.PS2DIV(Div), .FIFO_DEPTH(Depth)) dut (
    .i_clk_sys      (clk),
    .i_reset        (rst),
    .i_key_data     (kdata),
    .i_key_strobe   (strobe),
    .o_full         (full),
    .o_overflow     (ovf),
    .o_busy         (busy),
    .o_ps2_clk_out  (ps2_clk),
    .o_ps2_data_out (ps2_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb[$];

  // Frame capture: sample data on every PS/2 clock fall
  logic        prev_clk = 1'b1;
  int          nbits = 0;
  logic [10:0] bits;
  int          falls = 0;
  int          first_fall = 0;
  int          last_fall = 0;
  int          frame_first[$];
  int          ovf_cnt = 0;

  task automatic check_frame();
    exp_t e;
    chk("frame expected", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("start bit", bits[0], 0);
      chk("data byte", bits[8:1], e.data);
      chk("parity bit", bits[9], e.par);
      chk("stop bit", bits[10], 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
    end else begin
      if (ovf) ovf_cnt++;
      if (prev_clk && !ps2_clk) begin
        if (nbits == 0) begin
          first_fall = cyc;
          frame_first.push_back(cyc);
        end
        last_fall = cyc;
        falls++;
        bits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          check_frame();
        end
      end
    end
    prev_clk = ps2_clk;
  end

  // Caller sits on a negedge; returns on the following negedge
  task automatic send(input logic [7:0] d, input logic accept);
    exp_t e;
    kdata  = d;
    strobe = 1'b1;
    if (accept) begin
      e.data = d;
      e.par  = ~^d;
      sb.push_back(e);
    end
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic run_one(input logic [7:0] d, input logic par);
    int   t;
    exp_t e;
    @(negedge clk);
    t = cyc;
    falls = 0;
    chk("busy before strobe", busy, 0);
    kdata  = d;
    strobe = 1'b1;
    e.data = d;
    e.par  = par;
    sb.push_back(e);
    @(negedge clk);
    strobe = 1'b0;
    chk("busy at t+1", busy, 1);
    chk("data idle at t+1", ps2_data, 1);
    @(negedge clk);
    chk("start bit at t+2", ps2_data, 0);
    chk("clk high at t+2", ps2_clk, 1);
    wait_until(t + 98);
    chk("busy through gap", busy, 1);
    @(negedge clk);
    chk("busy drop", busy, 0);
    chk("clk idle after", ps2_clk, 1);
    chk("data idle after", ps2_data, 1);
    chk("clock fall count", falls, 11);
    chk("first fall offset", first_fall - t, 6);
    chk("fall span", last_fall - first_fall, 80);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[5];
  int   t0;
  int   ovf0;

  initial begin
    vecs[0] = '{8'h1C, 1'b0};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h80, 1'b0};
    vecs[4] = '{8'h55, 1'b1};

    #2 rst = 1'b1;
    #1;
    chk("reset clk", ps2_clk, 1);
    chk("reset data", ps2_data, 1);
    chk("reset full", full, 0);
    chk("reset overflow", ovf, 0);
    chk("reset busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_one(vecs[i].data, vecs[i].par);
    chk("no overflow in table", ovf_cnt, 0);

`ifdef PS2_TX_FIFO_EN
    @(negedge clk);
    frame_first.delete();
    t0 = cyc;
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    wait_until(t0 + 200);
    chk("b2b frame count", frame_first.size(), 2);
    if (frame_first.size() == 2) chk("b2b pitch", frame_first[1] - frame_first[0], 96);
    chk("b2b no overflow", ovf_cnt, 0);

    @(negedge clk);
    ovf0 = ovf_cnt;
    t0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) chk("full after 5 writes", full, 1);
      send(8'(i), (i <= 5) ? 1'b1 : 1'b0);
    end
    chk("overflow pulse", ovf, 1);
    wait_until(t0 + 97);
    chk("full held until pop", full, 1);
    @(negedge clk);
    chk("full freed by pop", full, 0);
    wait_until(t0 + 490);
    chk("overflow count", ovf_cnt - ovf0, 1);
    chk("fifo frames drained", sb.size(), 0);
`else
    @(negedge clk);
    ovf0 = ovf_cnt;
    t0 = cyc;
    send(8'hAA, 1'b1);
    chk("hold full", full, 1);
    send(8'hBB, 1'b0);
    chk("hold overflow", ovf, 1);
    wait_until(t0 + 10);
    chk("hold freed in send", full, 0);
    send(8'hCC, 1'b1);
    chk("hold refilled", full, 1);
    wait_until(t0 + 97);
    chk("hold full before pop", full, 1);
    @(negedge clk);
    chk("hold freed at pop", full, 0);
    wait_until(t0 + 200);
    chk("hold overflow count", ovf_cnt - ovf0, 1);
    chk("hold frames drained", sb.size(), 0);
`endif

    @(negedge clk);
    t0 = cyc;
    send(8'h55, 1'b1);
    wait_until(t0 + 47);
    chk("clk low in bit 5", ps2_clk, 0);
    rst = 1'b1;
    #1;
    chk("abort clk high", ps2_clk, 1);
    chk("abort data high", ps2_data, 1);
    chk("abort busy", busy, 0);
    chk("abort full", full, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_one(8'h12, 1'b1);

    repeat (20) @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard transmitter: accepts scancode bytes from core logic, buffers them, and serializes each as an 11-bit PS/2 frame on the open-collector-style clock/data pair. It is the other end of the PS/2 receiver inside `lynx48`. It is used wherever the core itself must originate keyboard traffic, such as macro/autotype injection, self-test, or the PS/2 feed on targets without a host-side generator. It runs entirely in `clk_sys` and generates the PS/2 clock with an integer divider.

## Interface
- `PS2DIV`, 1103: PS/2 half-period in `clk_sys` cycles (≥2).
- `FIFO_DEPTH`, 16: byte FIFO depth, a power of two from 2 to 256. Used only when `PS2_TX_FIFO_EN` is defined.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_data`  in  8  scancode byte to send.
- `key_strobe`  in  1  one-cycle write of `key_data`.
- `full`  out  1  buffer cannot accept a write this cycle.
- `overflow`  out  1  one-cycle pulse: a write was dropped.
- `busy`  out  1  a frame or gap is in progress, or the buffer is non-empty.
- `ps2_clk_out`  out  1  PS/2 clock; idle high.
- `ps2_data_out`  out  1  PS/2 data; idle high.

## Operation
- Write acceptance:
  - A strobe is accepted when `full`=0 in that cycle.
  - If `full`=1, the byte is dropped and `overflow` pulses on the next cycle.
  - A pop in the same cycle does not rescue a write made while `full`=1.
- Frame format, sent LSB first: start 0, d0..d7, odd parity (`~^byte`), stop 1. That is 11 bits.
- Each bit occupies two half-periods:
  - Phase H: clock high, data presents the bit.
  - Phase L: clock low, data unchanged.
  - The receiver samples on the falling edge.
- States:
  - IDLE: lines high. If the buffer is non-empty, pop the byte into the shift register, clear the divider, load the bit index to 0, and go to SEND.
  - SEND: phase H then phase L per bit, each PS2DIV cycles long. After phase L of bit 10, go to GAP.
  - GAP: two half-periods with both lines high. Then go to SEND if the buffer is non-empty (popping as in IDLE), otherwise go to IDLE.
- Divider:
  - Counts 0..PS2DIV-1 and asserts a tick at PS2DIV-1, wrapping to 0.
  - It is held at 0 in IDLE.
- The bit index counts 0..10, and the phase toggles on every tick.
- Data order is preserved. The buffer is a circular FIFO with read/write pointers one bit wider than the address, so full and empty are distinguished on wrap-around.

## Timing
- Reset values, all applied asynchronously: `ps2_clk_out`=1, `ps2_data_out`=1, `full`=0, `overflow`=0, `busy`=0. The FIFO is emptied and the state is IDLE.
- Reset mid-frame aborts the frame immediately and drives both lines high. The partial byte is not retransmitted.
- Strobe at cycle t into an empty buffer while in IDLE:
  - The byte is stored at t+1 and `busy`=1 from t+1.
  - The pop occurs at t+1 and `ps2_data_out`=0 at t+2.
  - `ps2_clk_out` falls at t+2+PS2DIV.
- Frame length is 22·PS2DIV cycles. Byte-to-byte pitch with a non-empty buffer is 24·PS2DIV cycles.
- `ps2_data_out` changes only on phase-H entry, which is PS2DIV cycles before each clock fall.
- All outputs are registered.
- `full` is asserted in the cycle after the write that fills the buffer, and deasserted in the cycle after the pop.
- `busy` drops 1 cycle after GAP ends with an empty buffer.

## Configuration
- `PS2_TX_FIFO_EN`:
  - Defined: a FIFO of `FIFO_DEPTH` bytes.
  - Undefined: a single holding register. `full` = holding register valid, and `FIFO_DEPTH` is ignored. A second strobe before the pop overflows. The pop timing is identical, so the holding register frees at the start of SEND.

## Test plan
- Frame content (PS2DIV=4): strobe 0x1C. Bits sampled on clock falls are 0,0,0,1,1,1,0,0,0,0,1, with parity 0. Exactly 11 clock falls, the frame lasts 88 cycles, and the lines are high afterwards.
- Parity case: strobe 0x00. The parity bit is 1 and the stop bit is 1.
- Back-to-back: strobe 0xF0 then 0x1C on consecutive cycles. Both frames are received in order, the start bits are 96 cycles apart, and `overflow` never pulses.
- Overflow (FIFO_DEPTH=4, FIFO enabled): 6 strobes on consecutive cycles (0x01–0x06).
  - `full`=1 after the 4th stored byte; the pop frees a slot only at the start of SEND.
  - Strobes made while `full`=1 are dropped, each followed by an `overflow` pulse.
  - The bytes sent equal the accepted bytes, in order.
- Mid-frame reset: assert `reset` during bit 5 of 0x55. Both lines go high without waiting for a clock edge and `busy`=0. After release, a new strobe of 0x12 is sent correctly.
- FIFO disabled: strobe 0xAA, then 0xBB on the next cycle, and 0xCC during SEND.
  - 0xBB is dropped and `overflow` pulses.
  - 0xCC is accepted, because the holding register frees at the start of SEND.
  - Sent: 0xAA, then 0xCC.
